bcd_conv_sched: RTL and testbench

Round-robin scheduler that shares one 8-bit binary-to-BCD converter among N_REQ requesters.

---
 rtl/bcd_sched_pkg.sv | 18 +
 rtl/bcd_conv_sched_rr_arb.sv | 33 +++
 rtl/bcd_conv_sched.sv | 127 ++++++++++++
 tb/tb_bcd_conv_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD converter scheduler.
package bcd_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned CONV_LAT_DEF = 4;

  // Width of a down-counter that must hold the value lat.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/bcd_conv_sched_rr_arb.sv
// Combinational round-robin picker: first set request above i_ptr, with wrap.
module rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    int unsigned cand;
    logic [IW-1:0] w_sel;
    logic w_found;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    cand    = 0;
    w_sel   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand  = (32'(i_ptr) + k) % N;
      w_sel = IW'(cand);
      if (i_en && !w_found && i_req[w_sel]) begin
        w_found      = 1'b1;
        o_gnt[w_sel] = 1'b1;
        o_idx        = w_sel;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Shares one binary-to-BCD converter among N_REQ requesters, one conversion
// at a time, answering over a valid/ready response channel.
module bcd_conv_sched
  import bcd_sched_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned DW       = DATA_W,
  parameter int unsigned CONV_LAT = CONV_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    grant,
  output logic [DW-1:0]       conv_bin,
  input  logic [3:0]          conv_dec0,
  input  logic [3:0]          conv_dec1,
  input  logic [3:0]          conv_dec2,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ID_W-1:0]     resp_id,
  output logic [3:0]          resp_dec0,
  output logic [3:0]          resp_dec1,
  output logic [3:0]          resp_dec2,
  output logic                busy
);

  localparam int unsigned CW = cnt_width(CONV_LAT);

  if (CONV_LAT < 1) begin : g_lat_chk
    $error("CONV_LAT must be at least 1");
  end
  if (DW != DATA_W) begin : g_dw_chk
    $error("DW is fixed to the converter input width");
  end
  if (ID_W != ((N_REQ < 2) ? 1 : $clog2(N_REQ))) begin : g_idw_chk
    $error("ID_W must equal clog2(N_REQ)");
  end

  state_t          r_state, w_next;
  logic [ID_W-1:0] r_ptr, r_id, w_idx;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_conv_bin;
  logic [3:0]      r_dec0, r_dec1, r_dec2;
  logic            r_valid;
  logic            w_en;
  logic [N_REQ-1:0] w_gnt;

  // Gating on rst_n keeps grant at 0 while reset is held with requests pending.
  assign w_en = rst_n && (r_state == S_IDLE);

  rr_arb #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (|w_gnt)          w_next = S_CONV;
      S_CONV:  if (r_cnt == '0)     w_next = S_RESP;
      S_RESP:  if (resp_ready)      w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= ID_W'(N_REQ - 1);
      r_id       <= '0;
      r_cnt      <= '0;
      r_conv_bin <= '0;
      r_dec0     <= '0;
      r_dec1     <= '0;
      r_dec2     <= '0;
      r_valid    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|w_gnt) begin
            r_conv_bin <= req_data[w_idx*DW +: DW];
            r_id       <= w_idx;
            r_ptr      <= w_idx;
            r_cnt      <= CW'(CONV_LAT);
          end
        end
        S_CONV: begin
          // Counting down from CONV_LAT gives CONV_LAT+1 cycles of stable input.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_dec0  <= conv_dec0;
            r_dec1  <= conv_dec1;
            r_dec2  <= conv_dec2;
            r_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign grant      = w_gnt;
  assign conv_bin   = r_conv_bin;
  assign resp_valid = r_valid;
  assign resp_id    = r_id;
  assign resp_dec0  = r_dec0;
  assign resp_dec1  = r_dec1;
  assign resp_dec2  = r_dec2;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: pipelined converter stand-in, transaction-level
// reference model checked every cycle, plus directed literal expectations.
module tb_bcd_conv_sched;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int DW  = 8;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            resp_ready = 1'b1;
  logic [N-1:0]    grant;
  logic [DW-1:0]   conv_bin;
  logic [3:0]      conv_dec0, conv_dec1, conv_dec2;
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic [3:0]      resp_dec0, resp_dec1, resp_dec2;
  logic            busy;

  bcd_conv_sched #(
    .N_REQ    (N),
    .ID_W     (IDW),
    .DW       (DW),
    .CONV_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .conv_bin   (conv_bin),
    .conv_dec0  (conv_dec0),
    .conv_dec1  (conv_dec1),
    .conv_dec2  (conv_dec2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_dec0  (resp_dec0),
    .resp_dec1  (resp_dec1),
    .resp_dec2  (resp_dec2),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Converter stand-in: output reflects the input seen LAT edges earlier.
  logic [DW-1:0] cpipe [LAT] = '{default: '0};
  logic [DW-1:0] cv;
  always @(posedge clk) begin
    cpipe[0] <= conv_bin;
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign cv        = cpipe[LAT-1];
  assign conv_dec2 = 4'(cv / 100);
  assign conv_dec1 = 4'((cv / 10) % 10);
  assign conv_dec0 = 4'(cv % 10);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick_rr(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Reference model: phase 0 idle, 1 converting, 2 answering.
  int cyc = 0;
  int phase = 0;
  int m_ptr = N - 1;
  int m_id, m_data, m_n, cur_first, pk, eg;
  int m_conv = 0;
  logic [N-1:0] last_grant = '0;
  int g_id[$], g_cyc[$];
  int rs_id[$], rs_val[$], rs_first[$], rs_hs[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_conv_bin", conv_bin, 0);
      phase = 0; m_ptr = N - 1; m_conv = 0; last_grant = '0;
    end else begin
      eg = 0;
      pk = -1;
      if (phase == 0 && req != '0) begin
        pk = pick_rr(req, m_ptr);
        eg = 1 << pk;
      end
      chk("grant", grant, eg);
      chk("busy", busy, phase != 0);
      chk("resp_valid", resp_valid, phase == 2);
      chk("conv_bin", conv_bin, m_conv);
      if (phase == 2) begin
        chk("resp_id", resp_id, m_id);
        chk("resp_dec2", resp_dec2, m_data / 100);
        chk("resp_dec1", resp_dec1, (m_data / 10) % 10);
        chk("resp_dec0", resp_dec0, m_data % 10);
      end
      last_grant = grant;
      case (phase)
        0: if (pk >= 0) begin
          m_id = pk; m_data = int'(req_data[pk*DW +: DW]); m_conv = m_data;
          m_ptr = pk; m_n = 0; phase = 1;
          g_id.push_back(pk); g_cyc.push_back(cyc);
        end
        1: begin
          m_n++;
          if (m_n == LAT + 1) begin phase = 2; cur_first = cyc + 1; end
        end
        default: if (resp_ready) begin
          rs_id.push_back(int'(resp_id));
          rs_val.push_back(int'(resp_dec2) * 100 + int'(resp_dec1) * 10 + int'(resp_dec0));
          rs_first.push_back(cur_first);
          rs_hs.push_back(cyc);
          phase = 0;
        end
      endcase
    end
  end

  logic [N-1:0] autodrop = '1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (autodrop[i] && last_grant[i]) req[i] = 1'b0;
    end
  endtask

  task automatic set_data(input int i, input int v);
    req_data[i*DW +: DW] = DW'(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  int gb, rb;
  int t2_vals[4] = '{0, 9, 99, 255};
  int t4_vals[4] = '{42, 200, 42, 200};
  int t4_ids[4]  = '{0, 3, 0, 3};
  int n1;

  initial begin
    tick(2);
    chk("init_busy", busy, 0);
    chk("init_valid", resp_valid, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: single request, latency and digits
    gb = g_id.size(); rb = rs_id.size();
    set_data(2, 173); req[2] = 1'b1;
    tick(12);
    chk("t1_ngrant", g_id.size() - gb, 1);
    chk("t1_gid", g_id[gb], 2);
    chk("t1_rid", rs_id[rb], 2);
    chk("t1_digits", rs_val[rb], 173);
    chk("t1_valid_lat", rs_first[rb] - g_cyc[gb], 6);
    chk("t1_hs_lat", rs_hs[rb] - g_cyc[gb], 6);

    // 2: all four requesters, rotation from 0 after reset
    do_reset();
    gb = g_id.size(); rb = rs_id.size();
    set_data(0, 0); set_data(1, 9); set_data(2, 99); set_data(3, 255);
    req = 4'hF;
    tick(40);
    chk("t2_ngrant", g_id.size() - gb, 4);
    chk("t2_nresp", rs_id.size() - rb, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_gid", g_id[gb+k], k);
      chk("t2_rid", rs_id[rb+k], k);
      chk("t2_val", rs_val[rb+k], t2_vals[k]);
    end
    chk("t2_spacing", g_cyc[gb+1] - g_cyc[gb], LAT + 3);

    // 3: back-pressure with a pending requester
    gb = g_id.size(); rb = rs_id.size();
    resp_ready = 1'b0;
    set_data(0, 50); req[0] = 1'b1;
    tick(1);
    set_data(1, 7); req[1] = 1'b1;
    tick(16);
    chk("t3_busy", busy, 1);
    chk("t3_valid_held", resp_valid, 1);
    chk("t3_ngrant_held", g_id.size() - gb, 1);
    resp_ready = 1'b1;
    tick(12);
    chk("t3_ngrant", g_id.size() - gb, 2);
    chk("t3_gid1", g_id[gb+1], 1);
    chk("t3_grant_after_hs", g_cyc[gb+1] - rs_hs[rb], 1);
    chk("t3_val0", rs_val[rb], 50);
    chk("t3_val1", rs_val[rb+1], 7);

    // 4: two continuous requesters alternate
    do_reset();
    gb = g_id.size(); rb = rs_id.size();
    autodrop = 4'b0110;
    set_data(0, 42); set_data(3, 200);
    req = 4'b1001;
    tick(30);
    req = '0;
    autodrop = '1;
    tick(10);
    chk("t4_nresp_ge4", int'(rs_id.size() - rb >= 4), 1);
    for (int k = 0; k < 4; k++) begin
      chk("t4_gid", g_id[gb+k], t4_ids[k]);
      chk("t4_rid", rs_id[rb+k], t4_ids[k]);
      chk("t4_val", rs_val[rb+k], t4_vals[k]);
    end

    // 5: reset in the middle of a conversion
    gb = g_id.size(); rb = rs_id.size();
    autodrop = 4'b0111;
    set_data(3, 77); req[3] = 1'b1;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_valid", resp_valid, 0);
    chk("t5_conv_bin", conv_bin, 0);
    chk("t5_resp_id", resp_id, 0);
    chk("t5_digits", int'({resp_dec2, resp_dec1, resp_dec0}), 0);
    tick(2);
    autodrop = '1;
    rst_n = 1'b1;
    tick(12);
    chk("t5_ngrant", g_id.size() - gb, 2);
    chk("t5_gid", g_id[gb+1], 3);
    chk("t5_nresp", rs_id.size() - rb, 1);
    chk("t5_rid", rs_id[rb], 3);
    chk("t5_val", rs_val[rb], 77);

    // 6: request raised during CONV and withdrawn before IDLE
    gb = g_id.size();
    set_data(2, 5); req[2] = 1'b1;
    tick(2);
    set_data(1, 123); req[1] = 1'b1;
    tick(2);
    req[1] = 1'b0;
    tick(12);
    n1 = 0;
    for (int k = gb; k < g_id.size(); k++) if (g_id[k] == 1) n1++;
    chk("t6_no_grant1", n1, 0);
    chk("t6_ngrant", g_id.size() - gb, 1);
    chk("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
